// File: rtl/calc_pkg.sv
// calc_pkg: shared ASCII constants, opcode and state encodings for the command parser
package calc_pkg;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SP    = 8'h20;
  localparam logic [7:0] CHR_0     = 8'h30;
  localparam logic [7:0] CHR_9     = 8'h39;
  localparam logic [7:0] CHR_PLUS  = 8'h2B;
  localparam logic [7:0] CHR_MINUS = 8'h2D;
  localparam logic [7:0] CHR_MUL   = 8'h2A;
  localparam logic [7:0] CHR_DIV   = 8'h2F;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
  typedef enum logic [1:0] {S_A, S_B, S_HOLD, S_ERR} state_e;
  function automatic logic is_op_chr(input logic [7:0] c);
    return c == CHR_PLUS || c == CHR_MINUS || c == CHR_MUL || c == CHR_DIV;
  endfunction
  function automatic op_e op_of(input logic [7:0] c);
    return c == CHR_MINUS ? OP_SUB : c == CHR_MUL ? OP_MUL : c == CHR_DIV ? OP_DIV : OP_ADD;
  endfunction
endpackage

// File: rtl/calc_cmd_parser_if.sv
// calc_cmd_parser_if: byte input, command handshake and status bundle of the parser
interface calc_cmd_parser_if;
  logic [7:0] usrt_data;
  logic       rdy;
  logic       cmd_ack;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] op_code;
  logic       cmd_valid;
  logic       cmd_err;
  logic       ovf;
  modport master (output usrt_data, rdy, cmd_ack, input op_a, op_b, op_code, cmd_valid, cmd_err, ovf);
  modport slave (input usrt_data, rdy, cmd_ack, output op_a, op_b, op_code, cmd_valid, cmd_err, ovf);
endinterface

// File: rtl/calc_dec_acc.sv
// calc_dec_acc: decimal digit accumulator shared by both operands
module calc_dec_acc #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       load,
  input  logic       clear,
  output logic [7:0] val,
  output logic [1:0] cnt,
  output logic       too_long,
  output logic       too_big
);
  logic [9:0]  acc;
  logic [13:0] nxt;
  assign nxt      = 14'(acc) * 14'd10 + 14'(digit);
  assign too_long = cnt == 2'(MAX_DIGITS);
  assign too_big  = nxt > 14'd255;
  assign val      = acc[7:0];
  // accumulate one digit per load; clear wins so an error or latch starts a fresh operand
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= nxt[9:0];
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/calc_cmd_parser.sv
// calc_cmd_parser: parses "<A><op><B>\r" ASCII lines into operand/opcode commands
module calc_cmd_parser
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input logic             clk,
  input logic             rst,
  calc_cmd_parser_if.slave bus
);
  state_e     state, state_nxt;
  logic [7:0] c;
  logic       is_dig, is_op, is_cr, is_sp;
  logic       proc, in_a, in_b, collect, dig_ok, ok;
  logic       load, clear, err, lat_a, lat_b;
  logic [7:0] val;
  logic [1:0] cnt;
  logic       too_long, too_big;
  logic [7:0] op_a_q, op_b_q, op_a_nxt, op_b_nxt;
  logic [1:0] op_code_q, op_code_nxt;
  logic       valid_q, err_q, ovf_q, valid_nxt, ovf_nxt;
  assign c       = bus.usrt_data;
  assign is_dig  = c >= CHR_0 && c <= CHR_9;
  assign is_op   = is_op_chr(c);
  assign is_cr   = c == CHR_CR;
  assign is_sp   = c == CHR_SP;
  assign proc    = bus.rdy && (state != S_HOLD || bus.cmd_ack);
  assign in_a    = state == S_A || state == S_HOLD;
  assign in_b    = state == S_B;
  assign collect = proc && (in_a || in_b);
  assign dig_ok  = is_dig && !too_long && !too_big;
  assign ok      = is_sp || dig_ok || (in_a && is_op && cnt != 0) || (in_a && is_cr && cnt == 0) || (in_b && is_cr && cnt != 0);
  assign err     = collect && !ok;
  assign load    = collect && dig_ok;
  assign lat_a   = collect && in_a && is_op && cnt != 0;
  assign lat_b   = collect && in_b && is_cr && cnt != 0;
  assign clear   = err || lat_a || lat_b;
  calc_dec_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc (
    .clk(clk), .rst(rst), .digit(c[3:0]), .load(load), .clear(clear),
    .val(val), .cnt(cnt), .too_long(too_long), .too_big(too_big)
  );
  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_A;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_a_q    <= op_a_nxt;
      op_b_q    <= op_b_nxt;
      op_code_q <= op_code_nxt;
      valid_q   <= valid_nxt;
      err_q     <= err;
      ovf_q     <= ovf_nxt;
    end
  end
  // next state: an error on '\r' already ends the line, otherwise skip to the next '\r'
  always_comb begin
    state_nxt = state;
    if (state == S_HOLD && bus.cmd_ack) state_nxt = S_A;
    if (state == S_ERR && bus.rdy && is_cr) state_nxt = S_A;
    if (lat_a) state_nxt = S_B;
    if (lat_b) state_nxt = S_HOLD;
    if (err) state_nxt = is_cr ? S_A : S_ERR;
  end
  // next outputs: operands latch on their terminator; ovf lives only while holding
  always_comb begin
    op_a_nxt    = lat_a ? val : op_a_q;
    op_code_nxt = lat_a ? op_of(c) : op_code_q;
    op_b_nxt    = lat_b ? val : op_b_q;
    valid_nxt   = lat_b || (valid_q && !bus.cmd_ack);
    ovf_nxt     = state == S_HOLD && !bus.cmd_ack && (ovf_q || bus.rdy);
  end
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_code   = op_code_q;
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_err   = err_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_calc_cmd_parser.sv
// tb_calc_cmd_parser: scoreboard bench for the ASCII command parser
module tb_calc_cmd_parser;
  typedef struct {
    bit is_err;
    int a;
    int b;
    int op;
  } exp_t;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t q[$];
  bit   vprev;
  bit   eprev;
  calc_cmd_parser_if bus ();
  calc_cmd_parser #(.MAX_DIGITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push_cmd(input int a, input int b, input int op);
    exp_t e;
    e.is_err = 1'b0;
    e.a = a;
    e.b = b;
    e.op = op;
    q.push_back(e);
  endtask
  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.a = 0;
    e.b = 0;
    e.op = 0;
    q.push_back(e);
  endtask
  task automatic send(input logic [7:0] b);
    bus.usrt_data = b;
    bus.rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.rdy = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic ack();
    bus.cmd_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_ack = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_op_a"}, bus.op_a, 0);
    chk({tag, "_op_b"}, bus.op_b, 0);
    chk({tag, "_op_code"}, bus.op_code, 0);
    chk({tag, "_valid"}, bus.cmd_valid, 0);
    chk({tag, "_err"}, bus.cmd_err, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      vprev = 1'b0;
      eprev = 1'b0;
    end else begin
      if (bus.cmd_valid && !vprev) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd: got a=%0d b=%0d op=%0d expected nothing", bus.op_a, bus.op_b, bus.op_code);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("cmd_kind_is_err", 0, int'(e.is_err));
          chk("cmd_op_a", bus.op_a, e.a);
          chk("cmd_op_b", bus.op_b, e.b);
          chk("cmd_op_code", bus.op_code, e.op);
        end
      end
      if (bus.cmd_err) begin
        chk("err_one_cycle", int'(eprev), 0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_err: got cmd_err=1 expected no pulse");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("err_kind_is_err", 1, int'(e.is_err));
        end
      end
      vprev = bus.cmd_valid;
      eprev = bus.cmd_err;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    bus.usrt_data = 8'h00;
    bus.rdy = 1'b0;
    bus.cmd_ack = 1'b0;
    #1;
    chk_zero("reset");
    idle(3);
    rst = 1'b1;
    idle(1);
    push_cmd(12, 34, 0);
    send_str("12+34\r");
    chk("valid_rise", bus.cmd_valid, 1);
    idle(2);
    chk("valid_hold", bus.cmd_valid, 1);
    ack();
    chk("valid_fall", bus.cmd_valid, 0);
    push_cmd(255, 0, 3);
    send_str("255/ 0\r");
    ack();
    push_err();
    send_str("25");
    send(8'h36);
    chk("err_on_6", bus.cmd_err, 1);
    send_str("*1\r");
    idle(2);
    chk("no_cmd_256", bus.cmd_valid, 0);
    push_err();
    send_str("+5\r");
    push_err();
    send_str("7-\r");
    push_err();
    send_str("1234+1\r");
    push_cmd(9, 9, 2);
    send_str("9*9\r");
    chk("valid_9x9", bus.cmd_valid, 1);
    ack();
    push_cmd(3, 1, 1);
    send_str("3-1\r");
    chk("ovf_clear_before", bus.ovf, 0);
    send(8'h35);
    chk("ovf_set", bus.ovf, 1);
    chk("hold_op_a", bus.op_a, 3);
    chk("hold_op_b", bus.op_b, 1);
    chk("hold_op_code", bus.op_code, 1);
    chk("hold_valid", bus.cmd_valid, 1);
    bus.cmd_ack = 1'b1;
    send(8'h34);
    bus.cmd_ack = 1'b0;
    chk("ack_rdy_valid", bus.cmd_valid, 0);
    chk("ack_rdy_ovf", bus.ovf, 0);
    push_cmd(4, 2, 1);
    send_str("-2\r");
    chk("valid_4m2", bus.cmd_valid, 1);
    chk("ovf_after_4m2", bus.ovf, 0);
    ack();
    send_str("12+3");
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    idle(2);
    rst = 1'b1;
    idle(1);
    push_cmd(5, 5, 0);
    send_str("5+5\r");
    chk("valid_5p5", bus.cmd_valid, 1);
    ack();
    send(8'h0D);
    idle(3);
    chk("empty_valid", bus.cmd_valid, 0);
    chk("empty_err", bus.cmd_err, 0);
    idle(2);
    chk("sb_pending", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calc_cmd_parser.md
# calc_cmd_parser

Downstream consumer of the synchronous serial receiver: takes each received byte (`usrt_data` qualified by the one-cycle `rdy` strobe) and parses ASCII command lines of the form `<A><op><B>\r`. A and B are unsigned decimals 0..255, and op is one of `+ - * /`. Each complete line is presented to the calculator core as two 8-bit operands plus a 2-bit opcode, over a valid/ack handshake. Malformed lines are flagged and discarded.

## Interface
- `MAX_DIGITS`, default 3: maximum decimal digits per operand.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `usrt_data`  in  8  received byte; sampled only when `rdy`=1.
- `rdy`  in  1  one-`clk` strobe marking a new byte.
- `cmd_ack`  in  1  core accepts the presented command.
- `op_a`  out  8  operand A; held stable while `cmd_valid`=1.
- `op_b`  out  8  operand B; held stable while `cmd_valid`=1.
- `op_code`  out  2  `+`=0, `-`=1, `*`=2, `/`=3.
- `cmd_valid`  out  1  command available; high until acked.
- `cmd_err`  out  1  one-cycle pulse per malformed line.
- `ovf`  out  1  sticky; a byte arrived while `cmd_valid`=1. Cleared by `cmd_ack`.

## Operation
- States:
  - S_A: collect operand A.
  - S_B: collect operand B.
  - S_HOLD: command presented, waiting for ack.
  - S_ERR: discard bytes to end of line.
- Space (0x20) is ignored in S_A, S_B and S_ERR. Digits are 0x30..0x39. End of line is 0x0D.
- Accumulator: 10-bit `acc`, 2-bit `cnt`. On each digit, `acc <= acc*10 + d` and `cnt++`.
- A digit arriving with `cnt==MAX_DIGITS` is an error. So is a result above 255.
- S_A:
  - Digit: accumulate.
  - Operator with `cnt>0`: latch A and op, clear `acc`/`cnt`, go to S_B.
  - Operator with `cnt==0`: error.
  - `\r` with `cnt==0`: empty line, ignored.
  - Any other byte: error.
- S_B:
  - Digit: accumulate.
  - `\r` with `cnt>0`: latch B, raise `cmd_valid`, go to S_HOLD.
  - Operator, `\r` with `cnt==0`, or any other byte: error.
- Error handling:
  - Pulse `cmd_err` and clear `acc`/`cnt`.
  - If the offending byte is `\r`, go to S_A. Otherwise go to S_ERR.
- S_ERR: drop all bytes. On `\r`, go to S_A. No second `cmd_err` pulse.
- S_HOLD:
  - `cmd_ack`: drop `cmd_valid`, go to S_A.
  - `rdy` without `cmd_ack`: drop the byte and set `ovf`.
  - `rdy` and `cmd_ack` in the same cycle: the ack is taken. The byte is processed as the first byte of the next line, evaluated as in S_A.
- `cmd_ack` while `cmd_valid`=0 is ignored.
- Division by zero and arithmetic overflow are not checked here; they belong to the core.

## Timing
- All outputs are registered.
- `cmd_valid` rises on the cycle after the `rdy` of the terminating `\r`.
- `cmd_err` pulses on the cycle after the offending `rdy`, for exactly 1 cycle.
- `cmd_valid` falls on the cycle after `cmd_ack` is sampled high.
- Back-to-back `rdy` on consecutive cycles is supported; every byte is handled in one cycle.
- Reset (asynchronous, any state, including mid-line):
  - State goes to S_A.
  - `acc`, `cnt`, `op_a`, `op_b`, `op_code`, `cmd_valid`, `cmd_err`, `ovf` all go to 0.
  - A partially received line is lost.
- After reset release, the first `rdy` is processed normally.

## Structure
- Package `calc_pkg` holds:
  - ASCII constants: CHR_CR, CHR_SP, CHR_0, CHR_9, CHR_PLUS, CHR_MINUS, CHR_MUL, CHR_DIV.
  - Opcode encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - State encoding.
- One sub-module, `calc_dec_acc`:
  - Holds `acc`/`cnt`.
  - Inputs: digit value, `load`, `clear`.
  - Flags: `too_long` and `too_big`.
  - Shared by both operands, since only one is collected at a time.
- The FSM, operand latches and handshake live in `calc_cmd_parser`.

## Test plan
- Bytes `"12+34\r"` -> `cmd_valid`=1 with `op_a`=12, `op_b`=34, `op_code`=0. `cmd_ack` -> `cmd_valid`=0 one cycle later.
- `"255/ 0\r"` -> `op_a`=255, `op_b`=0, `op_code`=3; space ignored. Then `"256*1\r"` -> `cmd_err` pulse on `'6'`, remaining bytes dropped, no `cmd_valid`.
- `"+5\r"`, `"7-\r"`, `"1234+1\r"` -> exactly one `cmd_err` pulse per line. The following `"9*9\r"` -> `op_a`=9, `op_b`=9, `op_code`=2.
- `"3-1\r"` with no ack, then `'5'` -> `ovf`=1 and outputs unchanged. `cmd_ack` together with `rdy` of `'4'`, then `"-2\r"` -> `op_a`=4, `op_b`=2, `op_code`=1, `ovf`=0.
- `rst` low asynchronously after `"12+3"` -> all outputs 0 immediately. After release, `"5+5\r"` -> `op_a`=5, `op_b`=5. Empty `"\r"` -> no response.
